// File: rtl/friscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// friscv_mem_arbiter : shares one single-port RAM between fetch and data ports
// Revision: 1.0
// ============================================================================
module friscv_mem_arbiter #(
  parameter int ADDRW         = 16,
  parameter int XLEN          = 32,
  parameter int DATA_PRIORITY = 0
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              inst_en,
  input  logic [ADDRW-1:0]  inst_addr,
  output logic [XLEN-1:0]   inst_rdata,
  output logic              inst_ready,
  input  logic              mem_en,
  input  logic              mem_wr,
  input  logic [ADDRW-1:0]  mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN/8-1:0] mem_strb,
  output logic [XLEN-1:0]   mem_rdata,
  output logic              mem_ready,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [ADDRW-1:0]  ram_addr,
  output logic [XLEN-1:0]   ram_wdata,
  output logic [XLEN/8-1:0] ram_strb,
  input  logic [XLEN-1:0]   ram_rdata,
  input  logic              ram_ready
);

  localparam int   STRBW     = XLEN / 8;
  localparam logic DATA_WINS = (DATA_PRIORITY != 0);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY_INST = 2'd1,
    BUSY_DATA = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic               last_data, last_data_nxt;
  logic               pick_data;
  logic               ram_en_nxt, ram_wr_nxt;
  logic [ADDRW-1:0]   ram_addr_nxt;
  logic [XLEN-1:0]    ram_wdata_nxt;
  logic [STRBW-1:0]   ram_strb_nxt;
  logic [XLEN-1:0]    inst_rdata_nxt, mem_rdata_nxt;
  logic               inst_ready_nxt, mem_ready_nxt;

  // On a collision the data port wins unless it was the previous winner (round-robin mode).
  assign pick_data = mem_en && (!inst_en || DATA_WINS || !last_data);

  always_comb begin
    state_nxt      = state;
    last_data_nxt  = last_data;
    ram_en_nxt     = ram_en;
    ram_wr_nxt     = ram_wr;
    ram_addr_nxt   = ram_addr;
    ram_wdata_nxt  = ram_wdata;
    ram_strb_nxt   = ram_strb;
    inst_rdata_nxt = inst_rdata;
    mem_rdata_nxt  = mem_rdata;
    inst_ready_nxt = 1'b0;
    mem_ready_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_data) begin
          ram_en_nxt    = 1'b1;
          ram_wr_nxt    = mem_wr;
          ram_addr_nxt  = mem_addr;
          ram_wdata_nxt = mem_wdata;
          ram_strb_nxt  = mem_strb;
          last_data_nxt = 1'b1;
          state_nxt     = BUSY_DATA;
        end else if (inst_en) begin
          ram_en_nxt    = 1'b1;
          ram_wr_nxt    = 1'b0;
          ram_addr_nxt  = inst_addr;
          ram_wdata_nxt = '0;
          ram_strb_nxt  = '0;
          last_data_nxt = 1'b0;
          state_nxt     = BUSY_INST;
        end
      end
      BUSY_INST: begin
        if (ram_ready) begin
          ram_en_nxt     = 1'b0;
          inst_rdata_nxt = ram_rdata;
          inst_ready_nxt = 1'b1;
          state_nxt      = RESP;
        end
      end
      BUSY_DATA: begin
        if (ram_ready) begin
          ram_en_nxt    = 1'b0;
          mem_rdata_nxt = ram_rdata;
          mem_ready_nxt = 1'b1;
          state_nxt     = RESP;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= IDLE;
      last_data  <= 1'b0;
      ram_en     <= 1'b0;
      ram_wr     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_strb   <= '0;
      inst_rdata <= '0;
      mem_rdata  <= '0;
      inst_ready <= 1'b0;
      mem_ready  <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_data  <= last_data_nxt;
      ram_en     <= ram_en_nxt;
      ram_wr     <= ram_wr_nxt;
      ram_addr   <= ram_addr_nxt;
      ram_wdata  <= ram_wdata_nxt;
      ram_strb   <= ram_strb_nxt;
      inst_rdata <= inst_rdata_nxt;
      mem_rdata  <= mem_rdata_nxt;
      inst_ready <= inst_ready_nxt;
      mem_ready  <= mem_ready_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_friscv_mem_arbiter.sv
`default_nettype none
// tb_friscv_mem_arbiter : instance 0 is round-robin, instance 1 is data-priority;
// a transaction-level model checks every output of both on every cycle.
module tb_friscv_mem_arbiter;

  localparam int ADDRW = 16;
  localparam int XLEN  = 32;
  localparam int STRBW = XLEN / 8;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic             aresetn    [2];
  logic             inst_en    [2];
  logic [ADDRW-1:0] inst_addr  [2];
  logic [XLEN-1:0]  inst_rdata [2];
  logic             inst_ready [2];
  logic             mem_en     [2];
  logic             mem_wr     [2];
  logic [ADDRW-1:0] mem_addr   [2];
  logic [XLEN-1:0]  mem_wdata  [2];
  logic [STRBW-1:0] mem_strb   [2];
  logic [XLEN-1:0]  mem_rdata  [2];
  logic             mem_ready  [2];
  logic             ram_en     [2];
  logic             ram_wr     [2];
  logic [ADDRW-1:0] ram_addr   [2];
  logic [XLEN-1:0]  ram_wdata  [2];
  logic [STRBW-1:0] ram_strb   [2];
  logic [XLEN-1:0]  ram_rdata  [2];
  logic             ram_ready  [2];

  friscv_mem_arbiter #(.ADDRW(ADDRW), .XLEN(XLEN), .DATA_PRIORITY(0)) dut0 (
    .aclk(aclk), .aresetn(aresetn[0]),
    .inst_en(inst_en[0]), .inst_addr(inst_addr[0]), .inst_rdata(inst_rdata[0]), .inst_ready(inst_ready[0]),
    .mem_en(mem_en[0]), .mem_wr(mem_wr[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_strb(mem_strb[0]), .mem_rdata(mem_rdata[0]), .mem_ready(mem_ready[0]),
    .ram_en(ram_en[0]), .ram_wr(ram_wr[0]), .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]),
    .ram_strb(ram_strb[0]), .ram_rdata(ram_rdata[0]), .ram_ready(ram_ready[0])
  );

  friscv_mem_arbiter #(.ADDRW(ADDRW), .XLEN(XLEN), .DATA_PRIORITY(1)) dut1 (
    .aclk(aclk), .aresetn(aresetn[1]),
    .inst_en(inst_en[1]), .inst_addr(inst_addr[1]), .inst_rdata(inst_rdata[1]), .inst_ready(inst_ready[1]),
    .mem_en(mem_en[1]), .mem_wr(mem_wr[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_strb(mem_strb[1]), .mem_rdata(mem_rdata[1]), .mem_ready(mem_ready[1]),
    .ram_en(ram_en[1]), .ram_wr(ram_wr[1]), .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]),
    .ram_strb(ram_strb[1]), .ram_rdata(ram_rdata[1]), .ram_ready(ram_ready[1])
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic cmp(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %h, expected %h", name, d, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- memory
  // Responds at +4 after each edge; fixed latency in directed mode, random otherwise.
  bit              rnd_mode = 1'b0;
  int              lat      [2];
  bit              force_rdy[2];
  logic [XLEN-1:0] fix_rdata[2];
  int              lat_cnt  [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      ram_ready[d] = 1'b0;
      ram_rdata[d] = '0;
      lat_cnt[d]   = 0;
    end
    forever begin
      @(posedge aclk);
      #4;
      for (int d = 0; d < 2; d++) begin
        if (ram_en[d]) begin
          if (rnd_mode) begin
            ram_ready[d] = ($urandom_range(0, 2) == 0);
            ram_rdata[d] = $urandom;
          end else if (lat_cnt[d] >= lat[d]) begin
            ram_ready[d] = 1'b1;
            ram_rdata[d] = fix_rdata[d];
          end else begin
            ram_ready[d] = 1'b0;
            lat_cnt[d]++;
          end
        end else begin
          lat_cnt[d]   = 0;
          ram_ready[d] = force_rdy[d] || (rnd_mode && $urandom_range(0, 7) == 0);
          ram_rdata[d] = rnd_mode ? $urandom : fix_rdata[d];
        end
      end
    end
  end

  // ---------------------------------------------------------------- model
  // Tracks the transaction in flight (owner and whether it has completed) and
  // the values every output must hold after each edge.
  bit               m_valid [2];
  bit               m_busy  [2];
  bit               m_resp  [2];
  bit               m_data  [2];   // owner of the transaction in flight: 1 = data
  bit               m_lastd [2];   // last winner: 1 = data
  logic             e_ram_en[2], e_ram_wr[2], e_iready[2], e_mready[2];
  logic [ADDRW-1:0] e_ram_addr[2];
  logic [XLEN-1:0]  e_ram_wdata[2], e_irdata[2], e_mrdata[2];
  logic [STRBW-1:0] e_ram_strb[2];

  initial begin
    for (int d = 0; d < 2; d++) m_valid[d] = 1'b0;
  end

  always begin
    @(posedge aclk);
    for (int d = 0; d < 2; d++) begin
      if (!aresetn[d]) begin
        m_valid[d] = 1'b1; m_busy[d] = 1'b0; m_resp[d] = 1'b0; m_lastd[d] = 1'b0;
        e_ram_en[d] = 1'b0; e_ram_wr[d] = 1'b0; e_ram_addr[d] = '0; e_ram_wdata[d] = '0;
        e_ram_strb[d] = '0; e_irdata[d] = '0; e_mrdata[d] = '0; e_iready[d] = 1'b0; e_mready[d] = 1'b0;
      end else if (m_resp[d]) begin
        m_resp[d] = 1'b0; e_iready[d] = 1'b0; e_mready[d] = 1'b0;
      end else if (m_busy[d]) begin
        if (ram_ready[d]) begin
          e_ram_en[d] = 1'b0;
          if (m_data[d]) begin e_mrdata[d] = ram_rdata[d]; e_mready[d] = 1'b1; end
          else           begin e_irdata[d] = ram_rdata[d]; e_iready[d] = 1'b1; end
          m_busy[d] = 1'b0; m_resp[d] = 1'b1;
        end
      end else if (inst_en[d] || mem_en[d]) begin
        bit win_data;
        if (inst_en[d] && mem_en[d]) win_data = (d == 1) ? 1'b1 : (m_lastd[d] ? 1'b0 : 1'b1);
        else                         win_data = mem_en[d];
        m_busy[d] = 1'b1; m_data[d] = win_data; m_lastd[d] = win_data; e_ram_en[d] = 1'b1;
        if (win_data) begin
          e_ram_wr[d] = mem_wr[d]; e_ram_addr[d] = mem_addr[d];
          e_ram_wdata[d] = mem_wdata[d]; e_ram_strb[d] = mem_strb[d];
        end else begin
          e_ram_wr[d] = 1'b0; e_ram_addr[d] = inst_addr[d]; e_ram_wdata[d] = '0; e_ram_strb[d] = '0;
        end
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      if (m_valid[d]) begin
        cmp("ram_en",     d, 32'(ram_en[d]),     32'(e_ram_en[d]));
        cmp("ram_wr",     d, 32'(ram_wr[d]),     32'(e_ram_wr[d]));
        cmp("ram_addr",   d, 32'(ram_addr[d]),   32'(e_ram_addr[d]));
        cmp("ram_wdata",  d, ram_wdata[d],       e_ram_wdata[d]);
        cmp("ram_strb",   d, 32'(ram_strb[d]),   32'(e_ram_strb[d]));
        cmp("inst_ready", d, 32'(inst_ready[d]), 32'(e_iready[d]));
        cmp("inst_rdata", d, inst_rdata[d],      e_irdata[d]);
        cmp("mem_ready",  d, 32'(mem_ready[d]),  32'(e_mready[d]));
        cmp("mem_rdata",  d, mem_rdata[d],       e_mrdata[d]);
      end
    end
  end

  // ---------------------------------------------------------------- directed helpers
  int               t_en [2], t_rdy [2], n_irdy [2], n_mrdy [2];
  logic [ADDRW-1:0] cap_addr  [2];
  logic             cap_wr    [2];
  logic [XLEN-1:0]  cap_wdata [2];
  logic [STRBW-1:0] cap_strb  [2];
  logic [XLEN-1:0]  cap_rdata [2];

  // Runs ncyc cycles from the +2 phase, recording grant/ready timing; requesters drop en on ready.
  task automatic run_txn(input int ncyc);
    for (int d = 0; d < 2; d++) begin
      t_en[d] = -1; t_rdy[d] = -1; n_irdy[d] = 0; n_mrdy[d] = 0;
    end
    for (int c = 0; c < ncyc; c++) begin
      @(posedge aclk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (ram_en[d] && t_en[d] < 0) begin
          t_en[d] = c; cap_addr[d] = ram_addr[d]; cap_wr[d] = ram_wr[d];
          cap_wdata[d] = ram_wdata[d]; cap_strb[d] = ram_strb[d];
        end
        if (inst_ready[d]) begin n_irdy[d]++; t_rdy[d] = c; cap_rdata[d] = inst_rdata[d]; end
        if (mem_ready[d])  begin n_mrdy[d]++; t_rdy[d] = c; cap_rdata[d] = mem_rdata[d]; end
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        if (inst_ready[d]) inst_en[d] = 1'b0;
        if (mem_ready[d])  mem_en[d]  = 1'b0;
      end
    end
  endtask

  bit exp_seq [2][4];
  int ng [2], nrdy [2], gcyc [2][4];
  bit gseq [2][4];
  bit prev_en [2];

  // ---------------------------------------------------------------- main
  initial begin
    exp_seq[0] = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_seq[1] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int d = 0; d < 2; d++) begin
      aresetn[d] = 1'b0; inst_en[d] = 1'b1; mem_en[d] = 1'b1;
      inst_addr[d] = 16'h0AAA; mem_addr[d] = 16'h0BBB; mem_wr[d] = 1'b0;
      mem_wdata[d] = '0; mem_strb[d] = '0;
      lat[d] = 0; force_rdy[d] = 1'b0; fix_rdata[d] = 32'h0;
      ng[d] = 0; nrdy[d] = 0; prev_en[d] = 1'b0;
    end

    // Reset held with both requests asserted.
    repeat (3) begin
      @(posedge aclk);
      #1;
      for (int d = 0; d < 2; d++) begin
        cmp("rst_ram_en",     d, 32'(ram_en[d]),     32'h0);
        cmp("rst_inst_ready", d, 32'(inst_ready[d]), 32'h0);
        cmp("rst_mem_ready",  d, 32'(mem_ready[d]),  32'h0);
        cmp("rst_ram_addr",   d, 32'(ram_addr[d]),   32'h0);
      end
    end

    // Continuous collision, immediate memory; data requester quits after the 3rd transaction.
    #1;
    for (int d = 0; d < 2; d++) aresetn[d] = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(posedge aclk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (ram_en[d] && !prev_en[d]) begin
          if (ng[d] < 4) begin
            gseq[d][ng[d]] = (ram_addr[d] == 16'h0BBB);
            gcyc[d][ng[d]] = c;
          end
          ng[d]++;
        end
        prev_en[d] = ram_en[d];
        if (inst_ready[d] || mem_ready[d]) nrdy[d]++;
      end
      #1;
      for (int d = 0; d < 2; d++)
        if (nrdy[d] == 3 && (inst_ready[d] || mem_ready[d])) mem_en[d] = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      cmp("grant_count", d, 32'(ng[d] >= 4), 32'h1);
      for (int k = 0; k < 4; k++) begin
        cmp("grant_is_data", d, 32'(gseq[d][k]), 32'(exp_seq[d][k]));
        cmp("grant_cycle",   d, 32'(gcyc[d][k]), 32'(3 * k));
      end
    end

    // Clean restart, then a single fetch with 2-cycle memory latency.
    for (int d = 0; d < 2; d++) begin aresetn[d] = 1'b0; inst_en[d] = 1'b0; mem_en[d] = 1'b0; end
    @(posedge aclk);
    #2;
    for (int d = 0; d < 2; d++) begin
      aresetn[d] = 1'b1; inst_en[d] = 1'b1; inst_addr[d] = 16'h0010;
      lat[d] = 2; fix_rdata[d] = 32'hDEADBEEF;
    end
    run_txn(10);
    for (int d = 0; d < 2; d++) begin
      cmp("fetch_t_en",  d, 32'(t_en[d]),     32'd0);
      cmp("fetch_t_rdy", d, 32'(t_rdy[d]),    32'd3);
      cmp("fetch_npuls", d, 32'(n_irdy[d]),   32'd1);
      cmp("fetch_nmrdy", d, 32'(n_mrdy[d]),   32'd0);
      cmp("fetch_addr",  d, 32'(cap_addr[d]), 32'h0010);
      cmp("fetch_wr",    d, 32'(cap_wr[d]),   32'h0);
      cmp("fetch_strb",  d, 32'(cap_strb[d]), 32'h0);
      cmp("fetch_rdata", d, cap_rdata[d],     32'hDEADBEEF);
    end

    // Data write, 1-cycle latency.
    for (int d = 0; d < 2; d++) begin
      mem_en[d] = 1'b1; mem_wr[d] = 1'b1; mem_addr[d] = 16'h0100;
      mem_wdata[d] = 32'h12345678; mem_strb[d] = 4'h3;
      lat[d] = 1; fix_rdata[d] = 32'h0BADF00D;
    end
    run_txn(8);
    for (int d = 0; d < 2; d++) begin
      cmp("wr_t_en",    d, 32'(t_en[d]),      32'd0);
      cmp("wr_t_rdy",   d, 32'(t_rdy[d]),     32'd2);
      cmp("wr_npuls",   d, 32'(n_mrdy[d]),    32'd1);
      cmp("wr_nirdy",   d, 32'(n_irdy[d]),    32'd0);
      cmp("wr_addr",    d, 32'(cap_addr[d]),  32'h0100);
      cmp("wr_wr",      d, 32'(cap_wr[d]),    32'h1);
      cmp("wr_wdata",   d, cap_wdata[d],      32'h12345678);
      cmp("wr_strb",    d, 32'(cap_strb[d]),  32'h3);
      cmp("wr_irdata",  d, inst_rdata[d],     32'hDEADBEEF);
    end

    // Reset during a slow data read, then a stray ram_ready.
    for (int d = 0; d < 2; d++) begin
      mem_en[d] = 1'b1; mem_wr[d] = 1'b0; mem_addr[d] = 16'h0200; lat[d] = 5;
    end
    @(posedge aclk);
    #1;
    for (int d = 0; d < 2; d++) cmp("mid_ram_en_on", d, 32'(ram_en[d]), 32'h1);
    #1;
    for (int d = 0; d < 2; d++) begin aresetn[d] = 1'b0; mem_en[d] = 1'b0; end
    @(posedge aclk);
    #1;
    for (int d = 0; d < 2; d++) begin
      cmp("mid_ram_en_off", d, 32'(ram_en[d]),    32'h0);
      cmp("mid_mem_ready",  d, 32'(mem_ready[d]), 32'h0);
    end
    #1;
    for (int d = 0; d < 2; d++) begin aresetn[d] = 1'b1; force_rdy[d] = 1'b1; end
    repeat (4) begin
      @(posedge aclk);
      #1;
      for (int d = 0; d < 2; d++) begin
        cmp("late_mem_ready", d, 32'(mem_ready[d]), 32'h0);
        cmp("late_ram_en",    d, 32'(ram_en[d]),    32'h0);
      end
      #1;
      for (int d = 0; d < 2; d++) force_rdy[d] = 1'b0;
    end

    // Randomized traffic with occasional resets; checked by the model only.
    rnd_mode = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge aclk);
      #2;
      for (int d = 0; d < 2; d++) begin
        aresetn[d] = ($urandom_range(0, 299) != 0);
        if (inst_ready[d] || !inst_en[d]) begin
          inst_en[d]   = ($urandom_range(0, 2) != 0);
          inst_addr[d] = 16'($urandom);
        end else if (m_busy[d] && !m_data[d]) begin
          inst_addr[d] = 16'($urandom);
        end
        if (mem_ready[d] || !mem_en[d]) begin
          mem_en[d]    = ($urandom_range(0, 2) != 0);
          mem_wr[d]    = 1'($urandom);
          mem_addr[d]  = 16'($urandom);
          mem_wdata[d] = $urandom;
          mem_strb[d]  = 4'($urandom);
        end else if (m_busy[d] && m_data[d]) begin
          mem_addr[d]  = 16'($urandom);
          mem_wdata[d] = $urandom;
          mem_strb[d]  = 4'($urandom);
          mem_wr[d]    = 1'($urandom);
        end
      end
    end

    repeat (2) @(posedge aclk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/friscv_mem_arbiter.md
Name: friscv_mem_arbiter

Overview:
- Shares one single-port memory (unified instruction+data RAM) between the core's instruction fetch port and its data memory port.
- Sits between the rv32i core and the memory.
- Per transaction: picks one requester, forwards its request on the shared port, waits for completion, then returns read data with a one-cycle ready pulse.
- Collisions resolve round-robin, or with fixed data priority.

Parameters:
- ADDRW, 16, address width of both requester ports and the shared port
- XLEN, 32, data width; strobe width is XLEN/8
- DATA_PRIORITY, 0, 1 = data port always wins a collision; 0 = round-robin between the ports

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- inst_en  in  1  fetch request; held high until inst_ready
- inst_addr  in  ADDRW  fetch address
- inst_rdata  out  XLEN  fetched word; valid while inst_ready=1
- inst_ready  out  1  one-cycle completion pulse for fetch
- mem_en  in  1  data request; held high until mem_ready
- mem_wr  in  1  1 = write, 0 = read
- mem_addr  in  ADDRW  data address
- mem_wdata  in  XLEN  write data
- mem_strb  in  XLEN/8  write byte strobes
- mem_rdata  out  XLEN  read data; valid while mem_ready=1
- mem_ready  out  1  one-cycle completion pulse for data
- ram_en  out  1  shared-port request; held until ram_ready
- ram_wr  out  1  shared-port write
- ram_addr  out  ADDRW  shared-port address
- ram_wdata  out  XLEN  shared-port write data
- ram_strb  out  XLEN/8  shared-port strobes
- ram_rdata  in  XLEN  memory read data; valid with ram_ready
- ram_ready  in  1  memory completion

Behaviour:
- Reset: aresetn sampled at the rising edge of aclk only (no async path).
  - While low: state=IDLE; all outputs 0; last_grant=INST, so data wins the first round-robin collision.
  - Reset mid-transaction abandons it; no ready pulse is issued.
- All outputs are registered.
- FSM states: IDLE, BUSY_INST, BUSY_DATA, RESP.
- IDLE:
  - Only inst_en → register inst_addr to ram_addr; ram_wr=0; ram_strb=0; ram_wdata=0; ram_en=1 next cycle; go BUSY_INST.
  - Only mem_en → register mem_wr/addr/wdata/strb to ram_*; ram_en=1; go BUSY_DATA.
  - Both high: DATA_PRIORITY=1 → data wins; otherwise the port not in last_grant wins.
  - last_grant updates to the winner.
- BUSY_x:
  - ram_* held stable, ram_en=1, until ram_ready=1 is sampled.
  - On that edge: ram_en←0; ram_rdata captured into the winner's rdata register; winner's ready←1; go RESP.
  - Write transactions still capture ram_rdata (don't-care value).
- RESP:
  - Winner's ready=1 for exactly this cycle; next edge ready←0, go IDLE.
  - A requester samples ready in RESP and updates its en for IDLE, so a completed request is never re-granted.
- inst_rdata and mem_rdata hold their last captured values when not ready; the loser's outputs are untouched.
- Latency:
  - Request seen in IDLE at cycle 0 → ram_en=1 at cycle 1.
  - ram_ready at cycle N≥1 → ready pulse at cycle N+1 → IDLE at N+2.
  - Minimum round trip 3 cycles; peak throughput 1 transaction per 3 cycles.
- The losing request stays pending (its en held high) and is granted from the next IDLE. With DATA_PRIORITY=0 neither port waits more than one foreign transaction.
- Requester dropping en while BUSY is a protocol violation: the shared transaction completes, the ready pulse is still issued, and there is no check.
- Request inputs are ignored outside IDLE; changes to addr/data during BUSY do not affect ram_*.
- ram_ready outside BUSY_x is ignored.

Test Plan:
- Reset: hold aresetn=0 for 3 cycles with inst_en=mem_en=1 → all outputs 0, ram_en stays 0; after release, data is granted first (last_grant=INST).
- Single fetch: inst_en=1, inst_addr=0x0010; memory returns 0xDEADBEEF with ram_ready 2 cycles after ram_en → ram_addr=0x0010, ram_wr=0, ram_strb=0; inst_ready pulses 1 cycle with inst_rdata=0xDEADBEEF; mem_ready stays 0.
- Data write: mem_en=1, mem_wr=1, mem_addr=0x0100, mem_wdata=0x12345678, mem_strb=0x3 → ram_* carry exactly these values; mem_ready pulses once; inst_rdata unchanged.
- Round-robin collision (DATA_PRIORITY=0): both ports request continuously for 4 transactions, ram_ready immediate → grant order D,I,D,I; each transaction takes 3 cycles.
- Fixed priority (DATA_PRIORITY=1): mem_en held high for 3 transactions with inst_en high → 3 data grants, then fetch is granted once mem_en drops.
- Reset mid-operation: aresetn=0 during BUSY_DATA before ram_ready → next cycle ram_en=0, no mem_ready pulse, state IDLE; a late ram_ready is ignored.
